// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : shares one single-port sram between a CPU port and a loader
//                port, with bounded burst ownership (round-robin or fixed).
// Revision     : 1.0
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_BURST     = 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WORD_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [WORD_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [WORD_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [WORD_WIDTH-1:0] o_sram_data,
  output logic                  o_sram_we,
  input  logic [WORD_WIDTH-1:0] i_sram_data
);

  localparam int                 c_cnt_w     = $clog2(MAX_BURST) + 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_served_q, last_served_d;
  logic [c_cnt_w-1:0] beat_cnt_q, beat_cnt_d;
  logic               m0_rvalid_q, m0_rvalid_d;
  logic               m1_rvalid_q, m1_rvalid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      m0_rvalid_q   <= 1'b0;
      m1_rvalid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      m0_rvalid_q   <= m0_rvalid_d;
      m1_rvalid_q   <= m1_rvalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || PRIORITY_MODE == 1 || last_served_q)) begin
          state_d = GRANT0;
        end else if (m1_req) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_req) begin
          state_d = m1_req ? GRANT1 : IDLE;
        end else if (beat_cnt_q == c_last_beat) begin
          // Fixed priority never hands over while port 0 keeps requesting.
          if (m1_req && PRIORITY_MODE == 0) begin
            state_d = GRANT1;
          end else begin
            beat_cnt_d = '0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      GRANT1: begin
        if (!m1_req) begin
          state_d = m0_req ? GRANT0 : IDLE;
        end else if (beat_cnt_q == c_last_beat) begin
          if (m0_req) begin
            state_d = GRANT0;
          end else begin
            beat_cnt_d = '0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      beat_cnt_d = '0;
      if (state_d == GRANT0) begin
        last_served_d = 1'b0;
      end else if (state_d == GRANT1) begin
        last_served_d = 1'b1;
      end
    end
  end

  always_comb begin
    o_sram_addr = '0;
    o_sram_data = '0;
    o_sram_we   = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    case (state_q)
      GRANT0: begin
        o_sram_addr = m0_addr;
        o_sram_data = m0_wdata;
        o_sram_we   = m0_we & m0_req;
        m0_rvalid_d = m0_req & ~m0_we;
      end
      GRANT1: begin
        o_sram_addr = m1_addr;
        o_sram_data = m1_wdata;
        o_sram_we   = m1_we & m1_req;
        m1_rvalid_d = m1_req & ~m1_we;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = (state_q == GRANT0);
  assign m1_gnt    = (state_q == GRANT1);
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = i_sram_data;
  assign m1_rdata  = i_sram_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter : self-checking bench for sram_arbiter with an sram model.
// Revision        : 1.0
// ============================================================================
module tb_sram_arbiter;
  localparam int AW = 12;
  localparam int WW = 16;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, o_sram_addr;
  logic [WW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, o_sram_data, i_sram_data;
  logic o_sram_we;

  logic p0_req, p1_req, p_gnt0, p_gnt1, p_rv0, p_rv1, p_we;
  logic [AW-1:0] p_addr;
  logic [WW-1:0] p_data, p_rd0, p_rd1;

  logic pl_we = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [WW-1:0] pl_data;
  logic [WW-1:0] mem [0:4095];

  int errors = 0;
  int checks = 0;

  sram_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_BURST(MB), .PRIORITY_MODE(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .o_sram_we(o_sram_we),
    .i_sram_data(i_sram_data)
  );

  sram_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_BURST(4), .PRIORITY_MODE(1)) dut_p (
    .clk(clk), .reset(reset),
    .m0_req(p0_req), .m0_we(1'b0), .m0_addr(12'd0), .m0_wdata(16'd0),
    .m0_gnt(p_gnt0), .m0_rdata(p_rd0), .m0_rvalid(p_rv0),
    .m1_req(p1_req), .m1_we(1'b0), .m1_addr(12'd0), .m1_wdata(16'd0),
    .m1_gnt(p_gnt1), .m1_rdata(p_rd1), .m1_rvalid(p_rv1),
    .o_sram_addr(p_addr), .o_sram_data(p_data), .o_sram_we(p_we),
    .i_sram_data(16'd0)
  );

  always #5 clk = ~clk;

  // Single-port sram: write at the edge, registered read data.
  always @(posedge clk) begin
    if (o_sram_we) mem[o_sram_addr] <= o_sram_data;
    if (pl_we) mem[pl_addr] <= pl_data;
    i_sram_data <= mem[o_sram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    p0_req = 0; p1_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    m0_addr = 12'd123; m0_wdata = 16'hbeef; m0_we = 1'b1;
    m1_addr = 12'd77;  m1_wdata = 16'h1234; m1_we = 1'b1;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_m0_rvalid got=%b exp=0", m0_rvalid); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_m1_rvalid got=%b exp=0", m1_rvalid); end
    checks++; if (o_sram_we !== 1'b0) begin errors++; $display("FAIL reset_sram_we got=%b exp=0", o_sram_we); end
    checks++; if (o_sram_addr !== 12'd0) begin errors++; $display("FAIL reset_sram_addr got=%0d exp=0", o_sram_addr); end
    checks++; if (o_sram_data !== 16'd0) begin errors++; $display("FAIL reset_sram_data got=%0h exp=0", o_sram_data); end
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    preload(12'd100, 16'd85);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd100;
    tick();
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt_c1 got=%b exp=1", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL single_m1_gnt got=%b exp=0", m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_c1 got=%b exp=0", m0_rvalid); end
    #1;
    checks++; if (o_sram_addr !== 12'd100) begin errors++; $display("FAIL single_addr got=%0d exp=100", o_sram_addr); end
    tick();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid_c2 got=%b exp=1", m0_rvalid); end
    checks++; if (m0_rdata !== 16'd85) begin errors++; $display("FAIL single_rdata got=%0d exp=85", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid got=%b exp=0", m1_rvalid); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_scores();
    int i, sent, got, guard, sum;
    logic beat;
    logic [WW-1:0] expq[$];
    logic [WW-1:0] e;
    do_reset();
    i = 0; guard = 0;
    while (i < 10 && guard < 60) begin
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(100 + i); m1_wdata = WW'(i + 1);
      #1 beat = m1_gnt;
      tick();
      if (beat) i++;
      guard++;
    end
    idle_inputs();
    checks++; if (i !== 10) begin errors++; $display("FAIL scores_writes got=%0d exp=10", i); end
    sent = 0; got = 0; sum = 0; guard = 0;
    while (got < 10 && guard < 80) begin
      if (m0_rvalid) begin
        e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
        checks++; if (m0_rdata !== e) begin errors++; $display("FAIL scores_read got=%0d exp=%0d", m0_rdata, e); end
        sum += int'(m0_rdata);
        got++;
      end
      m0_req = (sent < 10); m0_we = 1'b0; m0_addr = AW'(100 + sent);
      #1 beat = m0_gnt && m0_req;
      if (beat) expq.push_back(WW'(sent + 1));
      tick();
      if (beat) sent++;
      guard++;
    end
    checks++; if (got !== 10) begin errors++; $display("FAIL scores_reads got=%0d exp=10", got); end
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'd99; m0_wdata = WW'(sum);
    guard = 0; beat = 1'b0;
    while (!beat && guard < 10) begin
      #1 beat = m0_gnt;
      tick();
      guard++;
    end
    idle_inputs();
    checks++; if (mem[99] !== 16'd55) begin errors++; $display("FAIL scores_sum got=%0d exp=55", mem[99]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp0, prev0;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    prev0 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      m0_addr = AW'($urandom_range(0, 15)); m1_addr = AW'($urandom_range(0, 15));
      tick();
      exp0 = (((c - 1) / MB) % 2) == 0;
      checks++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin
        errors++; $display("FAIL rr_gnt cycle=%0d got=%b%b exp=%b%b", c, m0_gnt, m1_gnt, exp0, !exp0);
      end
      if (c >= 2) begin
        checks++; if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin
          errors++; $display("FAIL rr_rvalid cycle=%0d got=%b%b exp=%b%b", c, m0_rvalid, m1_rvalid, prev0, !prev0);
        end
      end
      prev0 = exp0;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_long_burst();
    int w;
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      m1_addr = AW'($urandom_range(0, 15));
      tick();
      checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
        errors++; $display("FAIL long_hold cycle=%0d got=%b%b exp=01", c, m0_gnt, m1_gnt);
      end
    end
    m0_req = 1'b1; m0_we = 1'b0;
    w = 0;
    while (!m0_gnt && w < 20) begin
      tick();
      w++;
    end
    checks++; if (w < 1 || w > MB) begin errors++; $display("FAIL long_takeover wait=%0d exp=1..%0d", w, MB); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++; if (p_gnt0 !== 1'b1 || p_gnt1 !== 1'b0) begin
        errors++; $display("FAIL fixed_hold cycle=%0d got=%b%b exp=10", c, p_gnt0, p_gnt1);
      end
    end
    p0_req = 1'b0;
    tick();
    checks++; if (p_gnt1 !== 1'b1 || p_gnt0 !== 1'b0) begin
      errors++; $display("FAIL fixed_handover got=%b%b exp=01", p_gnt0, p_gnt1);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'd200;
    tick();
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got=%b exp=1", m0_gnt); end
    m0_addr = 12'd201;
    tick();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_rvalid_pre got=%b exp=1", m0_rvalid); end
    m0_addr = 12'd202;
    #2 reset = 1'b1;
    #1;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt_drop got=%b exp=0", m0_gnt); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_drop got=%b exp=0", m0_rvalid); end
    checks++; if (o_sram_we !== 1'b0 || o_sram_addr !== 12'd0) begin
      errors++; $display("FAIL midrst_bus got_we=%b got_addr=%0d exp=0/0", o_sram_we, o_sram_addr);
    end
    tick();
    reset = 1'b0;
    m1_req = 1'b0; m0_req = 1'b1;
    tick();
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL midrst_regrant got=%b exp=1", m0_gnt); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_stale_rvalid got=%b exp=0", m0_rvalid); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [WW-1:0] ref_mem [16];
    bit rq [2];
    bit wr [2];
    logic [AW-1:0] ad [2];
    logic [WW-1:0] wd [2];
    bit pend_v [2];
    logic [WW-1:0] pend_d [2];
    int owner, run, last, nxt;
    logic exp_we;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = WW'($urandom);
      preload(AW'(a), ref_mem[a]);
    end
    owner = -1; run = 0; last = 1;
    pend_v[0] = 0; pend_v[1] = 0;
    for (int c = 0; c < 500; c++) begin
      checks++; if (m0_gnt !== (owner == 0) || m1_gnt !== (owner == 1)) begin
        errors++; $display("FAIL rand_gnt cycle=%0d got=%b%b exp_owner=%0d", c, m0_gnt, m1_gnt, owner);
      end
      checks++; if (m0_rvalid !== pend_v[0] || m1_rvalid !== pend_v[1]) begin
        errors++; $display("FAIL rand_rvalid cycle=%0d got=%b%b exp=%b%b", c, m0_rvalid, m1_rvalid, pend_v[0], pend_v[1]);
      end
      for (int p = 0; p < 2; p++) begin
        if (pend_v[p]) begin
          checks++; if (i_sram_data !== pend_d[p] || m0_rdata !== pend_d[p] || m1_rdata !== pend_d[p]) begin
            errors++; $display("FAIL rand_rdata cycle=%0d port=%0d got=%0h exp=%0h", c, p, m0_rdata, pend_d[p]);
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        rq[p] = ($urandom_range(0, 9) < 7);
        wr[p] = ($urandom_range(0, 2) == 0);
        ad[p] = AW'($urandom_range(0, 15));
        wd[p] = WW'($urandom);
      end
      m0_req = rq[0]; m0_we = wr[0]; m0_addr = ad[0]; m0_wdata = wd[0];
      m1_req = rq[1]; m1_we = wr[1]; m1_addr = ad[1]; m1_wdata = wd[1];
      #1;
      exp_we = (owner >= 0) ? (rq[owner] && wr[owner]) : 1'b0;
      checks++; if (o_sram_we !== exp_we) begin
        errors++; $display("FAIL rand_we cycle=%0d got=%b exp=%b", c, o_sram_we, exp_we);
      end
      if (owner >= 0 && rq[owner]) begin
        checks++; if (o_sram_addr !== ad[owner]) begin
          errors++; $display("FAIL rand_addr cycle=%0d got=%0d exp=%0d", c, o_sram_addr, ad[owner]);
        end
      end else if (owner < 0) begin
        checks++; if (o_sram_addr !== 12'd0) begin
          errors++; $display("FAIL rand_idle_addr cycle=%0d got=%0d exp=0", c, o_sram_addr);
        end
      end
      // Reference: one beat per owned, requesting cycle; ownership by the arbitration rules.
      pend_v[0] = 0; pend_v[1] = 0;
      if (owner >= 0 && rq[owner]) begin
        if (wr[owner]) ref_mem[ad[owner][3:0]] = wd[owner];
        else begin
          pend_v[owner] = 1;
          pend_d[owner] = ref_mem[ad[owner][3:0]];
        end
      end
      nxt = owner;
      if (owner < 0) begin
        if (rq[0] && rq[1]) nxt = (last == 1) ? 0 : 1;
        else if (rq[0]) nxt = 0;
        else if (rq[1]) nxt = 1;
      end else if (!rq[owner]) begin
        nxt = rq[1 - owner] ? 1 - owner : -1;
      end else if (run == MB - 1) begin
        nxt = rq[1 - owner] ? 1 - owner : owner;
        run = 0;
      end else begin
        run++;
      end
      if (nxt != owner) begin
        run = 0;
        if (nxt >= 0) last = nxt;
      end
      owner = nxt;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_scores();
    test_round_robin();
    test_long_burst();
    test_fixed_priority();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
